// File: rtl/spr_pentile_packer_if.sv
// Stream bundle between the SPR output stage and the pentile packer:
// sparse 96-bit SPR groups in, dense 64-bit pentile groups plus status out.
interface spr_pentile_packer_if #(
    parameter int GRP_W = 9
);
    logic             i_hs;
    logic             i_vs;
    logic             i_valid;
    logic [95:0]      i_data;
    logic [GRP_W-1:0] i_h_groups;
    logic             o_hs;
    logic             o_vs;
    logic             o_de;
    logic [63:0]      o_data;
    logic             o_line_odd;
    logic             o_fmt_err;
    logic             o_len_err;

    modport master (
        output i_hs, i_vs, i_valid, i_data, i_h_groups,
        input  o_hs, o_vs, o_de, o_data, o_line_odd, o_fmt_err, o_len_err
    );

    modport slave (
        input  i_hs, i_vs, i_valid, i_data, i_h_groups,
        output o_hs, o_vs, o_de, o_data, o_line_odd, o_fmt_err, o_len_err
    );
endinterface

// File: rtl/spr_pentile_packer.sv
// Packs the sparse SPR subpixel stream into a dense pentile stream, tracking
// line parity like the SPR does and flagging format and line-length errors.
module spr_pentile_packer #(
    parameter int SYNC_DLY = 21,
    parameter int GRP_W    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spr_pentile_packer_if.slave   bus
);

    logic                valid_d1_q;
    logic                hs_d1_q;
    logic                par_q, par_d;
    logic [GRP_W-1:0]    cnt_q, cnt_d;
    logic [GRP_W-1:0]    exp_q, exp_d;
    logic [SYNC_DLY-1:0] hs_dly_q;
    logic [SYNC_DLY-1:0] vs_dly_q;
    logic                de_q;
    logic [63:0]         data_q, data_d;
    logic                odd_q, odd_d;
    logic                fmt_q, fmt_d;
    logic                len_q, len_d;
    logic                valid_fall_s;
    logic                hs_fall_s;

    // R and B live in alternate byte slots depending on line parity; G never moves.
    function automatic logic [63:0] pack_slots(input logic [95:0] d, input logic odd);
        logic [63:0] p;
        if (odd) begin
            p = {d[87:80], d[71:64], d[63:32], d[31:24], d[15:8]};
        end else begin
            p = {d[95:88], d[79:72], d[63:32], d[23:16], d[7:0]};
        end
        return p;
    endfunction

    function automatic logic zero_slots_nz(input logic [95:0] d, input logic odd);
        logic nz;
        if (odd) begin
            nz = |{d[95:88], d[79:72], d[23:16], d[7:0]};
        end else begin
            nz = |{d[87:80], d[71:64], d[31:24], d[15:8]};
        end
        return nz;
    endfunction

    assign valid_fall_s = valid_d1_q & ~bus.i_valid;
    assign hs_fall_s    = hs_d1_q & ~bus.i_hs;

    // Next-state for parity, group counter, error flags and the output data word.
    always_comb begin
        par_d  = par_q;
        cnt_d  = cnt_q;
        exp_d  = exp_q;
        fmt_d  = fmt_q;
        len_d  = len_q;
        data_d = data_q;
        odd_d  = odd_q;
        if (!bus.i_vs) begin
            // Vertical blank overrides any line-end event landing in the same cycle.
            par_d = 1'b0;
            cnt_d = {GRP_W{1'b0}};
            fmt_d = 1'b0;
            len_d = 1'b0;
            exp_d = bus.i_h_groups;
        end else begin
            if (valid_fall_s) begin
                par_d = ~par_q;
            end else begin
                par_d = par_q;
            end
            if (bus.i_valid && zero_slots_nz(bus.i_data, par_q)) begin
                fmt_d = 1'b1;
            end else begin
                fmt_d = fmt_q;
            end
            if (valid_fall_s) begin
                if (cnt_q != exp_q) begin
                    len_d = 1'b1;
                end else begin
                    len_d = len_q;
                end
                cnt_d = {GRP_W{1'b0}};
            end else if (hs_fall_s) begin
                cnt_d = {GRP_W{1'b0}};
            end else if (bus.i_valid && bus.i_hs && (cnt_q != {GRP_W{1'b1}})) begin
                cnt_d = cnt_q + {{(GRP_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end
        if (bus.i_valid) begin
            data_d = pack_slots(bus.i_data, par_q);
            odd_d  = par_q;
        end else begin
            data_d = data_q;
            odd_d  = odd_q;
        end
    end

    // State, sync delay lines and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d1_q <= 1'b0;
            hs_d1_q    <= 1'b0;
            par_q      <= 1'b0;
            cnt_q      <= {GRP_W{1'b0}};
            exp_q      <= {GRP_W{1'b0}};
            hs_dly_q   <= {SYNC_DLY{1'b0}};
            vs_dly_q   <= {SYNC_DLY{1'b0}};
            de_q       <= 1'b0;
            data_q     <= 64'h0;
            odd_q      <= 1'b0;
            fmt_q      <= 1'b0;
            len_q      <= 1'b0;
        end else begin
            valid_d1_q <= bus.i_valid;
            hs_d1_q    <= bus.i_hs;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            hs_dly_q   <= {hs_dly_q[SYNC_DLY-2:0], bus.i_hs};
            vs_dly_q   <= {vs_dly_q[SYNC_DLY-2:0], bus.i_vs};
            de_q       <= bus.i_valid;
            data_q     <= data_d;
            odd_q      <= odd_d;
            fmt_q      <= fmt_d;
            len_q      <= len_d;
        end
    end

    assign bus.o_hs       = hs_dly_q[SYNC_DLY-1];
    assign bus.o_vs       = vs_dly_q[SYNC_DLY-1];
    assign bus.o_de       = de_q;
    assign bus.o_data     = data_q;
    assign bus.o_line_odd = odd_q;
    assign bus.o_fmt_err  = fmt_q;
    assign bus.o_len_err  = len_q;

endmodule

// File: tb/tb_spr_pentile_packer.sv
// Directed bench for spr_pentile_packer: packed groups are scoreboarded,
// sync outputs compared against a delay-line reference each cycle.
module tb_spr_pentile_packer;

    localparam int SYNC_DLY = 21;
    localparam int GRP_W    = 9;

    localparam logic [95:0] EVEN_D = {8'h44, 8'h00, 8'h33, 8'h00, 32'h0F0E0D0C, 8'h00, 8'h22, 8'h00, 8'h11};
    localparam logic [63:0] EVEN_E = 64'h44330F0E0D0C2211;
    localparam logic [95:0] ODD_D  = {8'h00, 8'hB1, 8'h00, 8'hB0, 32'h04030201, 8'hA1, 8'h00, 8'hA0, 8'h00};
    localparam logic [63:0] ODD_E  = 64'hB1B004030201A1A0;

    typedef struct packed {
        logic [63:0] data;
        logic        odd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t                sb[$];
    logic [SYNC_DLY-1:0] hs_hist = {SYNC_DLY{1'b0}};
    logic [SYNC_DLY-1:0] vs_hist = {SYNC_DLY{1'b0}};
    int                  n_chk   = 0;
    int                  n_pass  = 0;
    int                  line_idx = 0;

    always #5 clk = ~clk;

    spr_pentile_packer_if #(.GRP_W(GRP_W)) bus ();

    spr_pentile_packer #(.SYNC_DLY(SYNC_DLY), .GRP_W(GRP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hs"},   64'(bus.o_hs),       64'd0);
        check({tag, "_vs"},   64'(bus.o_vs),       64'd0);
        check({tag, "_de"},   64'(bus.o_de),       64'd0);
        check({tag, "_data"}, bus.o_data,          64'd0);
        check({tag, "_odd"},  64'(bus.o_line_odd), 64'd0);
        check({tag, "_fmt"},  64'(bus.o_fmt_err),  64'd0);
        check({tag, "_len"},  64'(bus.o_len_err),  64'd0);
    endtask

    // One clock: record sampled syncs, then compare outputs 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        hs_hist = {hs_hist[SYNC_DLY-2:0], bus.i_hs};
        vs_hist = {vs_hist[SYNC_DLY-2:0], bus.i_vs};
        #1;
        check("o_hs", 64'(bus.o_hs), 64'(hs_hist[SYNC_DLY-1]));
        check("o_vs", 64'(bus.o_vs), 64'(vs_hist[SYNC_DLY-1]));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("o_de",       64'(bus.o_de),       64'd1);
            check("o_data",     bus.o_data,          e.data);
            check("o_line_odd", 64'(bus.o_line_odd), 64'(e.odd));
        end else begin
            check("o_de_idle",  64'(bus.o_de),       64'd0);
        end
    endtask

    task automatic send_group(input logic [95:0] d, input logic [63:0] exp_data);
        exp_t e;
        e.data = exp_data;
        e.odd  = line_idx[0];
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        sb.push_back(e);
        tick();
    endtask

    task automatic rand_group(input logic bad);
        logic [7:0]  r0, r1, b0, b1;
        logic [31:0] g;
        logic [95:0] d;
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        g  = $urandom;
        if (line_idx[0]) begin
            d = {8'h00, b1, 8'h00, b0, g, r1, 8'h00, r0, 8'h00};
            if (bad) d[7:0] = 8'h01;
        end else begin
            d = {b1, 8'h00, b0, 8'h00, g, 8'h00, r1, 8'h00, r0};
            if (bad) d[15:8] = 8'h01;
        end
        send_group(d, {b1, b0, g, r1, r0});
    endtask

    task automatic run_line(input int n, input logic [95:0] fd, input logic [63:0] fe, input bit use_first);
        for (int i = 0; i < n; i++) begin
            if (use_first && i == 0) send_group(fd, fe);
            else rand_group(1'b0);
        end
    endtask

    task automatic end_line(input int gap);
        bus.i_valid = 1'b0;
        tick();
        line_idx++;
        bus.i_hs = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_hs       = 1'b0;
        bus.i_vs       = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_data     = 96'h0;
        bus.i_h_groups = 9'd0;
        #3;
        check_all_zero("reset");
        repeat (2) tick();
        rst_n          = 1'b1;
        bus.i_h_groups = 9'd10;
        repeat (3) tick();

        // Frame 1
        bus.i_vs = 1'b1;
        tick();
        bus.i_hs = 1'b1;
        tick();
        run_line(10, EVEN_D, EVEN_E, 1'b1);
        check("even_fmt", 64'(bus.o_fmt_err), 64'd0);
        end_line(3);
        check("len_10_ok", 64'(bus.o_len_err), 64'd0);

        bus.i_hs = 1'b1;
        tick();
        run_line(10, ODD_D, ODD_E, 1'b1);
        end_line(3);
        check("odd_len_ok", 64'(bus.o_len_err), 64'd0);

        bus.i_hs = 1'b1;
        tick();
        run_line(9, 96'h0, 64'h0, 1'b0);
        check("len_9_before", 64'(bus.o_len_err), 64'd0);
        bus.i_valid = 1'b0;
        tick();
        line_idx++;
        check("len_9_err", 64'(bus.o_len_err), 64'd1);
        bus.i_hs = 1'b0;
        repeat (3) tick();

        // Odd line followed by a single idle cycle, hs held high
        bus.i_hs = 1'b1;
        tick();
        run_line(10, 96'h0, 64'h0, 1'b0);
        bus.i_valid = 1'b0;
        tick();
        line_idx++;

        // Even line carrying one bad zero slot
        run_line(3, 96'h0, 64'h0, 1'b0);
        check("fmt_before", 64'(bus.o_fmt_err), 64'd0);
        rand_group(1'b1);
        check("fmt_set", 64'(bus.o_fmt_err), 64'd1);
        run_line(6, 96'h0, 64'h0, 1'b0);
        end_line(3);
        check("fmt_sticky", 64'(bus.o_fmt_err), 64'd1);
        check("len_sticky", 64'(bus.o_len_err), 64'd1);

        // Blank clears the sticky errors
        bus.i_vs = 1'b0;
        tick();
        check("blank_fmt_clr", 64'(bus.o_fmt_err), 64'd0);
        check("blank_len_clr", 64'(bus.o_len_err), 64'd0);
        repeat (2) tick();

        // Frame 2: short line ends exactly as vs drops
        line_idx = 0;
        bus.i_vs = 1'b1;
        tick();
        bus.i_hs = 1'b1;
        tick();
        run_line(9, 96'h0, 64'h0, 1'b0);
        bus.i_valid = 1'b0;
        bus.i_vs    = 1'b0;
        tick();
        check("vs_wins_len", 64'(bus.o_len_err), 64'd0);
        bus.i_hs = 1'b0;
        repeat (2) tick();

        // Frame 3 starts on an even line
        line_idx = 0;
        bus.i_vs = 1'b1;
        tick();
        bus.i_hs = 1'b1;
        tick();
        run_line(24, EVEN_D, EVEN_E, 1'b1);
        check("sb_drain", 64'(sb.size()), 64'd0);

        // Asynchronous reset mid-line, between clock edges
        #2;
        check("pre_rst_de", 64'(bus.o_de), 64'd1);
        check("pre_rst_hs", 64'(bus.o_hs), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
